// File: rtl/load_store_unit.sv
// Load/store stage: one byte/half/word access per op to a word-wide memory over req/ack.
// Latency: op_valid -> done is 1 edge on a fault, and at least 2 edges when memory is accessed.
// Backpressure: busy is high while a request is outstanding; op_valid seen while busy is dropped.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic {IDLE, REQ} state_t;

  // A timeout of 0 turns the watchdog off; TO_LAST is then never compared.
  localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  be_r;

  logic        legal;
  logic        fin_ok, fin_fault, fin_to;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, shifted, ld_ext;

  // Legality: encoding must be valid for the direction, and H/W must be naturally aligned.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~op_we;
      3'b101:  legal = ~op_we & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Store lane steering: replicate data into every lane so memory picks it via byte enables.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    if (op_we) begin
      case (funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << addr[1:0];
          wdata_nxt = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_nxt    = 4'b0011 << addr[1:0];
          wdata_nxt = {2{store_data[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = store_data;
        end
      endcase
    end
  end

  // Load alignment and extension, using the offset and size latched at issue.
  always_comb begin
    shifted = mem_rdata >> {off_r, 3'b000};
    case (f3_r)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and completion strobes; an ack beats a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    fin_ok    = 1'b0;
    fin_fault = 1'b0;
    fin_to    = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (legal) state_nxt = REQ;
          else       fin_fault = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          fin_ok    = 1'b1;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          state_nxt = IDLE;
          fin_to    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields, watchdog counter, result register and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 8'h0;
      we_r      <= 1'b0;
      f3_r      <= 3'b0;
      off_r     <= 2'b0;
      addr_r    <= 32'h0;
      be_r      <= 4'h0;
      wdata_r   <= 32'h0;
      load_data <= 32'h0;
      done      <= 1'b0;
      fault     <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      done    <= fin_ok | fin_fault | fin_to;
      fault   <= fin_fault;
      bus_err <= fin_to;
      if (state == IDLE && op_valid && legal) begin
        cnt     <= 8'h0;
        we_r    <= op_we;
        f3_r    <= funct3;
        off_r   <= addr[1:0];
        addr_r  <= {addr[31:2], 2'b00};
        be_r    <= be_nxt;
        wdata_r <= wdata_nxt;
      end else if (state == REQ) begin
        cnt <= cnt + 8'h1;
      end
      if (fin_ok && !we_r) load_data <= ld_ext;
    end
  end

  assign busy      = (state == REQ);
  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) & we_r;
  assign mem_addr  = addr_r;
  assign mem_be    = be_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a short watchdog (4 cycles).
// Directed vectors plus randomized ops checked against an arithmetic reference model.
// Memory ack latency and junk op_valid pulses are driven by the bench.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, fault, bus_err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ld = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_we(op_we), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
    .fault(fault), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !we;
      3'd5:    return !we && (a % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int o = int'(a % 4);
    if (!we) return 4'd15;
    if (f3 == 3'd0) return 4'(1 << o);
    if (f3 == 3'd1) return 4'(3 << o);
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] f3, input logic [31:0] sd);
    if (we && f3 == 3'd0) return (sd % 256) * 32'h01010101;
    if (we && f3 == 3'd1) return (sd % 65536) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    longint sh = longint'(rd) / (longint'(1) << (8 * (a % 4)));
    case (f3)
      3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 256; end
      3'd4: v = sh % 256;
      3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = sh % 65536;
      default: v = sh;
    endcase
    return 32'(v);
  endfunction

  // Issue one op, ack it after n cycles (1..4), optionally pulsing junk ops while busy.
  task automatic run_op(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int n, input logic [31:0] rd, input bit junk);
    bit lg = m_legal(we, f3, a);
    logic [31:0] e_addr = a - (a % 4);
    logic [3:0]  e_be = m_be(we, f3, a);
    logic [31:0] e_wd = m_wdata(we, f3, sd);
    op_valid = 1'b1; op_we = we; funct3 = f3; addr = a; store_data = sd;
    tick();
    op_valid = 1'b0;
    if (!lg) begin
      checks++;
      if (done !== 1'b1 || fault !== 1'b1 || bus_err !== 1'b0 || mem_req !== 1'b0 || load_data !== exp_ld) begin
        errors++;
        $display("FAIL %s fault: done=%b fault=%b bus_err=%b req=%b ld=%h, want 1 1 0 0 %h",
                 nm, done, fault, bus_err, mem_req, load_data, exp_ld);
      end
      tick();
      checks++;
      if (done !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL %s fault_pulse: done=%b fault=%b req=%b, want 0 0 0", nm, done, fault, mem_req);
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== we || mem_addr !== e_addr ||
          mem_be !== e_be || mem_wdata !== e_wd || done !== 1'b0) begin
        errors++;
        $display("FAIL %s req_cyc%0d: req=%b busy=%b we=%b addr=%h be=%b wd=%h done=%b, want 1 1 %b %h %b %h 0",
                 nm, i, mem_req, busy, mem_we, mem_addr, mem_be, mem_wdata, done, we, e_addr, e_be, e_wd);
      end
      if (junk) begin
        op_valid = 1'b1; op_we = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
      end
      if (i == n - 1) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
      tick();
    end
    mem_ack = 1'b0; op_valid = 1'b0; mem_rdata = $urandom;
    if (!we) exp_ld = m_load(f3, a, rd);
    checks++;
    if (done !== 1'b1 || fault !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 ||
        load_data !== exp_ld) begin
      errors++;
      $display("FAIL %s done: done=%b fault=%b bus_err=%b req=%b busy=%b ld=%h, want 1 0 0 0 0 %h",
               nm, done, fault, bus_err, mem_req, busy, load_data, exp_ld);
    end
    tick();
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 || load_data !== exp_ld) begin
      errors++;
      $display("FAIL %s after: done=%b req=%b busy=%b ld=%h, want 0 0 0 %h",
               nm, done, mem_req, busy, load_data, exp_ld);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b req=%b addr=%h be=%b wd=%h ld=%h, want all zero",
               busy, done, mem_req, mem_addr, mem_be, mem_wdata, load_data);
    end
    tick();
    rst_n = 1'b1;
    exp_ld = 32'h0;
    tick();
  endtask

  task automatic test_vectors();
    run_op("sb_1003", 1'b1, 3'b000, 32'h1003, 32'h000000A5, 1, 32'h0, 1'b0);
    run_op("lb_2002", 1'b0, 3'b000, 32'h2002, 32'h0, 1, 32'h00F00000, 1'b0);
    checks++;
    if (load_data !== 32'hFFFFFFF0) begin
      errors++; $display("FAIL lb_value: ld=%h want fffffff0", load_data);
    end
    run_op("lbu_2002", 1'b0, 3'b100, 32'h2002, 32'h0, 2, 32'h00F00000, 1'b0);
    checks++;
    if (load_data !== 32'h000000F0) begin
      errors++; $display("FAIL lbu_value: ld=%h want 000000f0", load_data);
    end
    run_op("lhu_2002", 1'b0, 3'b101, 32'h2002, 32'h0, 1, 32'h00F00000, 1'b0);
    run_op("lh_sign", 1'b0, 3'b001, 32'h3000, 32'h0, 1, 32'h1234_8001, 1'b0);
    run_op("sh_2", 1'b1, 3'b001, 32'h4002, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
    run_op("sw", 1'b1, 3'b010, 32'h4004, 32'hCAFE_F00D, 2, 32'h0, 1'b0);
    run_op("lw_2001", 1'b0, 3'b010, 32'h2001, 32'h0, 1, 32'h0, 1'b0);
    run_op("f3_011", 1'b0, 3'b011, 32'h2000, 32'h0, 1, 32'h0, 1'b0);
    run_op("sbu_illegal", 1'b1, 3'b100, 32'h2000, 32'h0, 1, 32'h0, 1'b0);
    run_op("lhu_odd", 1'b0, 3'b101, 32'h2003, 32'h0, 1, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    op_valid = 1'b1; op_we = 1'b0; funct3 = 3'b010; addr = 32'h5000;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: req=%b done=%b, want 1 0", i, mem_req, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || bus_err !== 1'b1 || fault !== 1'b0 || mem_req !== 1'b0 || load_data !== exp_ld) begin
      errors++;
      $display("FAIL timeout_err: done=%b bus_err=%b fault=%b req=%b ld=%h, want 1 1 0 0 %h",
               done, bus_err, fault, mem_req, load_data, exp_ld);
    end
    tick();
    checks++;
    if (done !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: done=%b bus_err=%b, want 0 0", done, bus_err);
    end
    run_op("ack_on_cycle4", 1'b0, 3'b000, 32'h5001, 32'h0, 4, 32'h0000_8000, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_op("ack3_junk", 1'b0, 3'b001, 32'h6002, 32'h0, 3, 32'hABCD_0000, 1'b1);
    run_op("st_junk", 1'b1, 3'b000, 32'h6001, 32'h0000_0077, 4, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid_req();
    op_valid = 1'b1; op_we = 1'b1; funct3 = 3'b010; addr = 32'h7000; store_data = 32'h1111_2222;
    tick();
    op_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_req: req=%b busy=%b we=%b ld=%h, want 0 0 0 0", mem_req, busy, mem_we, load_data);
    end
    exp_ld = 32'h0;
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_reset", 1'b0, 3'b000, 32'h7003, 32'h0, 2, 32'h8100_0000, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      logic [2:0]  f3 = 3'($urandom);
      logic        we = 1'($urandom);
      logic [31:0] a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        f3 = we ? 3'($urandom_range(0, 2)) : ($urandom_range(0, 1) != 0 ? 3'($urandom_range(0, 2))
                                                                          : 3'($urandom_range(4, 5)));
        a = (f3[1:0] == 2'b10) ? {a[31:2], 2'b00} : (f3[0] ? {a[31:1], 1'b0} : a);
      end
      run_op("rand", we, f3, a, $urandom, int'($urandom_range(1, 4)), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
